// File: rtl/controlador_disco_pkg.sv
// Shared CPU definitions: disk sequencer state encoding and disk opcodes.
package pkg_cpu;

  // Disk sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_REQ     = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4,
    ST_FAULT   = 3'd5
  } estado_disco_t;

  // Opcodes decoded by the control unit for the disk instructions
  localparam logic [5:0] OP_LDK = 6'b010110;
  localparam logic [5:0] OP_SDK = 6'b010111;

  // True for either disk opcode
  function automatic logic es_op_disco(input logic [5:0] op);
    return (op == OP_LDK) || (op == OP_SDK);
  endfunction

endpackage

// File: rtl/controlador_disco_verificador.sv
// Combinational partition bounds checker; also reused by the data-memory MMU.
module verificador_particao #(
  parameter int ADDR_W = 16
) (
  input  logic              userMode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] partBase,
  input  logic [ADDR_W-1:0] partLimit,
  output logic              violation
);

  logic [ADDR_W:0] offset;

  // One extra bit on the offset: a borrow (addr below base) is always out of range
  always_comb begin
    offset    = {1'b0, addr} - {1'b0, partBase};
    violation = userMode && (offset[ADDR_W] || (offset[ADDR_W-1:0] >= partLimit));
  end

endmodule

// File: rtl/controlador_disco.sv
// Disk port sequencer: stalls the pipeline and runs a 4-phase req/ack
// handshake with the external disk, bounds-checking user accesses.
module controlador_disco
  import pkg_cpu::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              isDisk,
  input  logic              diskWrite,
  input  logic              userMode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] partBase,
  input  logic [ADDR_W-1:0] partLimit,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdataValid,
  output logic              fault,
  output logic              disk_req,
  output logic              disk_we,
  output logic [ADDR_W-1:0] disk_addr,
  output logic [DATA_W-1:0] disk_wdata,
  input  logic              disk_ack,
  input  logic [DATA_W-1:0] disk_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  estado_disco_t state, state_next;
  logic [CNT_W-1:0] cnt;
  logic start, accept, violation;

  assign start = isDisk | diskWrite;

  // The latched address is checked; it equals addr while the instruction is held
  verificador_particao #(.ADDR_W(ADDR_W)) u_verificador (
    .userMode  (userMode),
    .addr      (disk_addr),
    .partBase  (partBase),
    .partLimit (partLimit),
    .violation (violation)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake/pipeline outputs
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    disk_req   = 1'b0;
    rdataValid = 1'b0;
    fault      = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        stall = start;
        if (isDisk && diskWrite) begin
          state_next = ST_FAULT;
        end else if (start && !disk_ack) begin
          accept     = 1'b1;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        stall      = 1'b1;
        state_next = violation ? ST_FAULT : ST_REQ;
      end
      ST_REQ: begin
        stall    = 1'b1;
        disk_req = 1'b1;
        if (disk_ack)              state_next = ST_RELEASE;
        else if (cnt == CNT_LAST)  state_next = ST_FAULT;
      end
      ST_RELEASE: begin
        stall = 1'b1;
        if (!disk_ack) state_next = ST_DONE;
      end
      ST_DONE: begin
        rdataValid = ~disk_we;
        state_next = ST_IDLE;
      end
      ST_FAULT: begin
        fault      = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request latches, REQ timeout counter and read-data capture
  always_ff @(posedge clock) begin
    if (reset) begin
      disk_we    <= 1'b0;
      disk_addr  <= '0;
      disk_wdata <= '0;
      cnt        <= '0;
      rdata      <= '0;
    end else begin
      if (accept) begin
        disk_we    <= ~isDisk;
        disk_addr  <= addr;
        disk_wdata <= wdata;
      end
      if (state == ST_REQ) cnt <= cnt + CNT_W'(1);
      else                 cnt <= '0;
      if (state == ST_REQ && disk_ack && !disk_we) rdata <= disk_rdata;
    end
  end

endmodule

// File: tb/tb_controlador_disco.sv
// Self-checking bench for controlador_disco: directed table, corner
// sequences and randomized transactions against a transaction-level model.
module tb_controlador_disco;

  localparam int TMO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        isDisk = 1'b0, diskWrite = 1'b0, userMode = 1'b0;
  logic [15:0] addr = '0, partBase = '0, partLimit = '0;
  logic [31:0] wdata = '0;
  logic        stall, rdataValid, fault, disk_req, disk_we;
  logic [31:0] rdata, disk_wdata;
  logic [15:0] disk_addr;
  logic        disk_ack;
  logic [31:0] disk_rdata = '0;

  int checks = 0;
  int errors = 0;

  // Disk responder state
  logic        resp_ack = 1'b0;
  logic        ack_hold = 1'b0;
  int          resp_delay = 0;
  int          rcnt = 0;
  logic [31:0] mem [int];

  // Reference model state
  logic [31:0] ref_mem [int];
  logic [31:0] ref_rd = '0;

  assign disk_ack = resp_ack | ack_hold;

  controlador_disco #(.DATA_W(32), .ADDR_W(16), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .isDisk(isDisk), .diskWrite(diskWrite),
    .userMode(userMode), .addr(addr), .wdata(wdata), .partBase(partBase),
    .partLimit(partLimit), .stall(stall), .rdata(rdata), .rdataValid(rdataValid),
    .fault(fault), .disk_req(disk_req), .disk_we(disk_we), .disk_addr(disk_addr),
    .disk_wdata(disk_wdata), .disk_ack(disk_ack), .disk_rdata(disk_rdata)
  );

  always #5 clock = ~clock;

  // Slow disk: acks after resp_delay+1 request cycles, drops ack once req falls
  always @(negedge clock) begin
    if (disk_req) begin
      rcnt++;
      if (rcnt > resp_delay && !resp_ack) begin
        if (disk_we) mem[int'(disk_addr)] = disk_wdata;
        disk_rdata = mem.exists(int'(disk_addr)) ? mem[int'(disk_addr)] : 32'h0;
        resp_ack   = 1'b1;
      end
    end else begin
      rcnt     = 0;
      resp_ack = 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // op: 0 read, 1 write, 2 illegal (both strobes)
  task automatic run_txn(input string tag, input int op, input bit um, input logic [15:0] a,
                         input logic [31:0] wd, input logic [15:0] base, input logic [15:0] lim,
                         input int delay, input bit ef, input int es, input int er,
                         input bit ev, input logic [31:0] erd);
    int n_stall = 0, n_req = 0, n_fault = 0, n_val = 0, bad_fld = 0, cyc = 0;
    bit ended = 0;
    @(negedge clock);
    resp_delay = delay;
    isDisk     = (op != 1);
    diskWrite  = (op != 0);
    userMode   = um;
    addr       = a;
    wdata      = wd;
    partBase   = base;
    partLimit  = lim;
    while (!ended && cyc < 64) begin
      #1;
      if (stall) n_stall++;
      if (fault) n_fault++;
      if (rdataValid) n_val++;
      if (disk_req) begin
        n_req++;
        if (disk_addr !== a || disk_we !== (op == 1)) bad_fld++;
        if (op == 1 && disk_wdata !== wd) bad_fld++;
      end
      if (!stall) ended = 1;
      else begin
        @(negedge clock);
        cyc++;
      end
    end
    isDisk = 0; diskWrite = 0;
    if (!ended) check({tag, " bounded"}, 0, 1);
    check({tag, " stall cycles"}, n_stall, es);
    check({tag, " req cycles"}, n_req, er);
    check({tag, " fault pulses"}, n_fault, ef ? 1 : 0);
    check({tag, " valid pulses"}, n_val, ev ? 1 : 0);
    check({tag, " rdata"}, rdata, erd);
    if (er > 0) check({tag, " req fields"}, bad_fld, 0);
    @(negedge clock); #1;
    check({tag, " idle after"}, {stall, fault, rdataValid, disk_req}, 4'b0);
  endtask

  typedef struct {
    string       tag;
    int          op;
    bit          um;
    logic [15:0] a;
    logic [31:0] wd;
    logic [15:0] base;
    logic [15:0] lim;
    int          delay;
    bit          ef;
    int          es;
    int          er;
    bit          ev;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs [$];

  initial begin
    mem[32'h40]     = 32'hDEADBEEF;
    ref_mem[32'h40] = 32'hDEADBEEF;

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    check("reset outputs", {stall, rdataValid, fault, disk_req, disk_we}, 5'b0);
    check("reset disk_addr", disk_addr, 0);
    check("reset disk_wdata", disk_wdata, 0);
    check("reset rdata", rdata, 0);
    reset = 0;

    //               tag          op um a        wd            base     lim    dly ef es     er   ev rdata
    vecs.push_back('{"kread",      0, 0, 16'h0040, 32'h0,        16'h0,   16'h0,   3, 0, 7,     4,   1, 32'hDEADBEEF});
    vecs.push_back('{"uwrite",     1, 1, 16'h10FF, 32'h12345678, 16'h1000,16'h0100,0, 0, 4,     1,   0, 32'hDEADBEEF});
    vecs.push_back('{"uread_top",  0, 1, 16'h10FF, 32'h0,        16'h1000,16'h0100,1, 0, 5,     2,   1, 32'h12345678});
    vecs.push_back('{"past_end",   0, 1, 16'h1100, 32'h0,        16'h1000,16'h0100,0, 1, 2,     0,   0, 32'h12345678});
    vecs.push_back('{"below_base", 1, 1, 16'h0FFF, 32'hAAAA5555, 16'h1000,16'h0100,0, 1, 2,     0,   0, 32'h12345678});
    vecs.push_back('{"zero_limit", 0, 1, 16'h1000, 32'h0,        16'h1000,16'h0000,0, 1, 2,     0,   0, 32'h12345678});
    vecs.push_back('{"wrap",       0, 1, 16'h0005, 32'h0,        16'hFFF0,16'h0020,0, 1, 2,     0,   0, 32'h12345678});
    vecs.push_back('{"ubase",      0, 1, 16'h1000, 32'h0,        16'h1000,16'h0100,0, 0, 4,     1,   1, 32'h0});
    vecs.push_back('{"kernel_any", 0, 0, 16'hFFFF, 32'h0,        16'h1000,16'h0000,0, 0, 4,     1,   1, 32'h0});
    vecs.push_back('{"timeout",    0, 0, 16'h0040, 32'h0,        16'h0,   16'h0,  20, 1, 2+TMO, TMO, 0, 32'h0});
    vecs.push_back('{"after_tmo",  0, 0, 16'h0040, 32'h0,        16'h0,   16'h0,   2, 0, 6,     3,   1, 32'hDEADBEEF});
    vecs.push_back('{"last_ack",   0, 0, 16'h10FF, 32'h0,        16'h0,   16'h0, TMO-1,0, 3+TMO, TMO, 1, 32'h12345678});
    vecs.push_back('{"illegal",    2, 0, 16'h0040, 32'h0,        16'h0,   16'h0,   0, 1, 1,     0,   0, 32'h12345678});

    foreach (vecs[i])
      run_txn(vecs[i].tag, vecs[i].op, vecs[i].um, vecs[i].a, vecs[i].wd, vecs[i].base,
              vecs[i].lim, vecs[i].delay, vecs[i].ef, vecs[i].es, vecs[i].er, vecs[i].ev,
              vecs[i].erd);
    ref_mem[32'h10FF] = 32'h12345678;

    // Sticky ack: request waits in IDLE with stall high until ack falls
    @(negedge clock);
    ack_hold = 1; isDisk = 1; addr = 16'h0040; userMode = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("sticky stall/no req", {stall, disk_req}, 2'b10);
      @(negedge clock);
    end
    ack_hold = 0; isDisk = 0;
    run_txn("after_sticky", 0, 0, 16'h0040, 0, 0, 0, 0, 0, 4, 1, 1, 32'hDEADBEEF);

    // Reset during REQ aborts silently
    @(negedge clock);
    resp_delay = 6; isDisk = 1; addr = 16'h10FF; userMode = 0;
    begin
      int w = 0;
      while (!disk_req && w < 10) begin @(negedge clock); #1; w++; end
      check("reached REQ", disk_req, 1);
    end
    @(negedge clock);
    reset = 1; isDisk = 0;
    @(negedge clock); #1;
    check("rst drops req", {disk_req, stall, fault, rdataValid}, 4'b0);
    check("rst rdata", rdata, 0);
    check("rst disk_addr", disk_addr, 0);
    reset = 0;
    begin
      int pulses = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clock); #1;
        if (fault || rdataValid || disk_req) pulses++;
      end
      check("no pulses after reset", pulses, 0);
    end
    ref_rd = '0;

    // Randomized transactions against the transaction-level model
    for (int t = 0; t < 60; t++) begin
      int r = $urandom_range(0, 9);
      int op = (r < 5) ? 0 : (r < 9) ? 1 : 2;
      bit um = 1'($urandom_range(0, 1));
      logic [15:0] base = 16'($urandom_range(0, 32));
      logic [15:0] lim  = 16'($urandom_range(0, 32));
      logic [15:0] a    = 16'($urandom_range(0, 80));
      logic [31:0] wd   = $urandom;
      int dly = $urandom_range(0, 10);
      bit ef = 0, ev = 0;
      int es, er;
      bit inside_part = (int'(a) >= int'(base)) && (int'(a) < int'(base) + int'(lim));
      if (op == 2) begin
        ef = 1; es = 1; er = 0;
      end else if (um && !inside_part) begin
        ef = 1; es = 2; er = 0;
      end else if (dly >= TMO) begin
        ef = 1; es = 2 + TMO; er = TMO;
      end else begin
        er = dly + 1; es = 3 + er;
        if (op == 0) begin
          ev = 1;
          ref_rd = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
        end else begin
          ref_mem[int'(a)] = wd;
        end
      end
      run_txn($sformatf("rnd%0d", t), op, um, a, wd, base, lim, dly, ef, es, er, ev, ref_rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controlador_disco.md
Name: controlador_disco

Overview:
- Multi-cycle sequencer for the disk port. Sits between the control unit's disk strobes (ldk read and sdk write) and the slow external disk memory.
- Freezes the PC and register write-back while a disk access is in flight.
- Runs a 4-phase req/ack handshake and bounds-checks user-mode accesses against a partition window.
- Returns read data together with a one-cycle write-back strobe.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 16, disk word-address width
- TIMEOUT, 1023, maximum cycles in REQ waiting for ack; must be ≥2

Ports:
- clock  in  1  system clock, all logic on the rising edge
- reset  in  1  synchronous, active-high
- isDisk  in  1  ldk decoded (read request)
- diskWrite  in  1  sdk decoded (write request)
- userMode  in  1  processor is in user mode; bounds check is enabled
- addr  in  ADDR_W  effective disk address from the ALU
- wdata  in  DATA_W  store data (rt) for sdk
- partBase  in  ADDR_W  user partition base
- partLimit  in  ADDR_W  user partition size in words
- stall  out  1  holds PC and pipeline
- rdata  out  DATA_W  read data, held until the next read completes
- rdataValid  out  1  one-cycle write-back strobe for ldk
- fault  out  1  one-cycle pulse on a bounds violation, timeout, or illegal request
- disk_req  out  1  handshake request
- disk_we  out  1  1 = write; valid while disk_req is high
- disk_addr  out  ADDR_W  latched address
- disk_wdata  out  DATA_W  latched write data
- disk_ack  in  1  handshake acknowledge (level)
- disk_rdata  in  DATA_W  read data; valid while disk_ack is high

Behaviour:

Reset values:
- State IDLE.
- All outputs 0, rdata 0, timeout counter 0.
- A reset asserted mid-access drops disk_req on the next edge. No rdataValid or fault is emitted for the aborted access.

States: IDLE, CHECK, REQ, RELEASE, DONE, FAULT.

IDLE:
- A request is start = isDisk | diskWrite.
- stall = start, combinationally, in the same cycle.
- Requests are accepted only when disk_ack = 0. If ack is still high from a prior transaction, remain in IDLE with stall = start.
- On acceptance, latch addr, wdata and op (read if isDisk) into disk_addr, disk_wdata and disk_we, then go to CHECK.
- isDisk and diskWrite both high: latch nothing and go to FAULT.

CHECK (stall = 1, one cycle):
- Violation if userMode = 1 and (addr < partBase or addr − partBase ≥ partLimit).
- The subtraction is ADDR_W+1 bits wide, so wrap-around is never treated as in-range.
- partLimit = 0 means every user access faults.
- Violation goes to FAULT; otherwise go to REQ.
- With userMode = 0 there is no check.

REQ (stall = 1):
- disk_req = 1; the counter increments each cycle.
- disk_ack = 1: on a read, capture disk_rdata into rdata on that edge; drop disk_req and go to RELEASE.
- Counter reaches TIMEOUT with no ack: drop disk_req and go to FAULT.

RELEASE (stall = 1):
- disk_req = 0. Wait for disk_ack = 0, then go to DONE.
- No timeout in this state.

DONE (stall = 0, one cycle):
- rdataValid = 1 if the op was a read. The instruction retires.
- Next state is IDLE unconditionally. The DONE cycle never samples start, so the retiring instruction cannot be re-issued.

FAULT (stall = 0, one cycle):
- fault = 1; rdata is unchanged; next state IDLE.
- The trap/PC redirect is owned by the control unit.

Latency and invariants:
- Minimum latency, start to DONE, is 5 cycles: IDLE → CHECK → REQ (ack the same cycle) → RELEASE (ack low) → DONE.
- disk_addr, disk_we and disk_wdata are stable from CHECK until DONE or FAULT.
- disk_req never reasserts before disk_ack has been observed low.

Decomposition:
- Shared package (pkg_cpu): state encoding constants, and the 6-bit opcode constants for ldk (010110) and sdk (010111), shared with the control unit.
- One natural sub-module: verificador_particao, a combinational bounds checker with inputs userMode, addr, partBase and partLimit and output violation. It is reused later by the data-memory MMU.

Test Plan:
- Kernel read: userMode=0, isDisk, addr=0x0040; the disk acks with 0xDEADBEEF 3 cycles after req → stall high for 7 cycles; rdata=0xDEADBEEF; rdataValid pulses once in DONE; fault=0.
- User write, in bounds: partBase=0x1000, partLimit=0x0100, addr=0x10FF, wdata=0x12345678 → disk_we=1, disk_addr=0x10FF, disk_wdata=0x12345678 during req; DONE with no rdataValid.
- Bounds faults: addr=0x1100 (one past the end) and addr=0x0FFF (below base) → no disk_req; fault pulses one cycle after CHECK; stall clears.
- Timeout: TIMEOUT=8 and the disk never acks → disk_req high for exactly 8 cycles, then fault pulses; a following request is accepted normally.
- Sticky ack and reset: hold disk_ack high after DONE while a new isDisk arrives → stays IDLE with stall=1 until ack falls. Separately, assert reset during REQ → disk_req=0 and state IDLE on the next edge; no pulses.
- Illegal request: isDisk=diskWrite=1 → fault on the next cycle; disk_req never asserted.
